// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MCU results queue and drain in idle slots.
// Optional macro WB_ARB_HAZARD_EN stalls writeback while a queued MCU entry targets the same register.
module wb_port_arbiter #(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_we,
    input  logic [DW-1:0] wb_res,
    input  logic [AW-1:0] wb_reg,
    input  logic          mc_valid,
    input  logic [DW-1:0] mc_res,
    input  logic [AW-1:0] mc_reg,
    output logic          mc_ready,
    output logic          stall,
    output logic          rf_we,
    output logic [DW-1:0] rf_data,
    output logic [AW-1:0] rf_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [GW-1:0] AGE_MAX = GW'(STARVE_LIMIT - 1);

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] reg_q  [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] age_q, age_d;
    logic          force_q, force_d;
    logic          rf_we_q, rf_we_d;
    logic [DW-1:0] rf_data_q, rf_data_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;

    logic hazard_s;
    logic stall_s;
    logic sel_wb_s;
    logic sel_fifo_s;
    logic ready_s;
    logic push_s;

    // Hazard detection against occupied FIFO entries (only when the option is built in)
    always_comb begin
        hazard_s = 1'b0;
`ifdef WB_ARB_HAZARD_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_we && (CW'(i) < count_q) && (reg_q[rd_ptr_q + PW'(i)] == wb_reg)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
`endif
    end

    // Source selection, FIFO bookkeeping, starvation ageing and write-port next state
    always_comb begin
        stall_s    = force_q | hazard_s;
        sel_wb_s   = wb_we & ~stall_s;
        sel_fifo_s = ~sel_wb_s & (count_q != {CW{1'b0}});
        ready_s    = rst_n & (count_q < DEPTH_C);
        push_s     = mc_valid & ready_s;

        rd_ptr_d = sel_fifo_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(sel_fifo_s);

        // A pop or an empty queue restarts the head's wait; reaching the limit forces a one-cycle stall
        force_d = 1'b0;
        if (sel_fifo_s || (count_d == {CW{1'b0}})) begin
            age_d = {GW{1'b0}};
        end else if (age_q == AGE_MAX) begin
            force_d = 1'b1;
            age_d   = {GW{1'b0}};
        end else begin
            age_d = age_q + GW'(1);
        end

        rf_we_d   = sel_wb_s | sel_fifo_s;
        rf_data_d = rf_data_q;
        rf_addr_d = rf_addr_q;
        if (sel_wb_s) begin
            rf_data_d = wb_res;
            rf_addr_d = wb_reg;
        end else if (sel_fifo_s) begin
            rf_data_d = data_q[rd_ptr_q];
            rf_addr_d = reg_q[rd_ptr_q];
        end else begin
            rf_data_d = rf_data_q;
            rf_addr_d = rf_addr_q;
        end
    end

    // Control state and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            age_q     <= {GW{1'b0}};
            force_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_data_q <= {DW{1'b0}};
            rf_addr_q <= {AW{1'b0}};
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            force_q   <= force_d;
            rf_we_q   <= rf_we_d;
            rf_data_q <= rf_data_d;
            rf_addr_q <= rf_addr_d;
        end
    end

    // MCU result storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {DW{1'b0}};
                reg_q[i]  <= {AW{1'b0}};
            end
        end else if (push_s) begin
            data_q[wr_ptr_q] <= mc_res;
            reg_q[wr_ptr_q]  <= mc_reg;
        end
    end

    assign stall    = stall_s;
    assign mc_ready = ready_s;
    assign rf_we    = rf_we_q;
    assign rf_data  = rf_data_q;
    assign rf_addr  = rf_addr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hazard sequence (when built in),
// then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we;
    logic [DW-1:0] wb_res;
    logic [AW-1:0] wb_reg;
    logic          mc_valid;
    logic [DW-1:0] mc_res;
    logic [AW-1:0] mc_reg;
    logic          mc_ready;
    logic          stall;
    logic          rf_we;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] rf_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_res(wb_res), .wb_reg(wb_reg),
        .mc_valid(mc_valid), .mc_res(mc_res), .mc_reg(mc_reg),
        .mc_ready(mc_ready), .stall(stall),
        .rf_we(rf_we), .rf_data(rf_data), .rf_addr(rf_addr)
    );

    typedef struct {
        logic          rst_n;
        logic          wb_we;
        logic [DW-1:0] wb_res;
        logic [AW-1:0] wb_reg;
        logic          mc_valid;
        logic [DW-1:0] mc_res;
        logic [AW-1:0] mc_reg;
        logic          e_stall;
        logic          e_ready;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: queued MCU results in arrival order plus the head's wait counter
    ent_t          mq[$];
    int            m_age   = 0;
    bit            m_force = 1'b0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    function automatic vec_t v(input logic r, input logic we, input logic [DW-1:0] wres,
                               input logic [AW-1:0] wreg, input logic mv, input logic [DW-1:0] mres,
                               input logic [AW-1:0] mreg, input logic es, input logic er,
                               input logic ewe, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        vec_t x;
        x.rst_n = r;   x.wb_we = we;    x.wb_res = wres; x.wb_reg = wreg;
        x.mc_valid = mv; x.mc_res = mres; x.mc_reg = mreg;
        x.e_stall = es; x.e_ready = er;  x.e_we = ewe;   x.e_addr = ea; x.e_data = ed;
        return x;
    endfunction

    function automatic bit model_stall();
        bit h = 1'b0;
`ifdef WB_ARB_HAZARD_EN
        foreach (mq[i]) begin
            if (wb_we && mq[i].r == wb_reg) h = 1'b1;
        end
`endif
        return m_force | h;
    endfunction

    function automatic bit model_ready();
        return rst_n && (mq.size() < DEPTH);
    endfunction

    task automatic model_update();
        bit   s, rdy, popped;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_age = 0; m_force = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            s = model_stall();
            rdy = (mq.size() < DEPTH);
            popped = 1'b0;
            if (wb_we && !s) begin
                m_we = 1'b1; m_addr = wb_reg; m_data = wb_res;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_addr = e.r; m_data = e.d;
                popped = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (mc_valid && rdy) mq.push_back({mc_reg, mc_res});
            if (popped || mq.size() == 0) begin
                m_age = 0; m_force = 1'b0;
            end else if (m_age == LIMIT - 1) begin
                m_age = 0; m_force = 1'b1;
            end else begin
                m_age++; m_force = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input vec_t x, input bit use_model);
        rst_n = x.rst_n; wb_we = x.wb_we; wb_res = x.wb_res; wb_reg = x.wb_reg;
        mc_valid = x.mc_valid; mc_res = x.mc_res; mc_reg = x.mc_reg;
        #1;
        if (use_model) begin
            chk("stall", {31'd0, stall}, {31'd0, model_stall()});
            chk("mc_ready", {31'd0, mc_ready}, {31'd0, model_ready()});
        end else begin
            chk("stall", {31'd0, stall}, {31'd0, x.e_stall});
            chk("mc_ready", {31'd0, mc_ready}, {31'd0, x.e_ready});
        end
        @(posedge clk);
        model_update();
        #1;
        if (use_model) begin
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            chk("rf_addr", {24'd0, rf_addr}, {24'd0, m_addr});
            chk("rf_data", {16'd0, rf_data}, {16'd0, m_data});
        end else begin
            chk("rf_we", {31'd0, rf_we}, {31'd0, x.e_we});
            chk("rf_addr", {24'd0, rf_addr}, {24'd0, x.e_addr});
            chk("rf_data", {16'd0, rf_data}, {16'd0, x.e_data});
        end
    endtask

    vec_t tbl[25];
    vec_t hz[4];
    vec_t rv;

    initial begin
        // rows: rst, wb_we, wb_res, wb_reg, mc_valid, mc_res, mc_reg | stall, ready, rf_we, rf_addr, rf_data
        tbl[0]  = v(1'b0, 1'b1, 16'h1111, 8'h01, 1'b1, 16'hAAAA, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tbl[1]  = v(1'b0, 1'b1, 16'h1111, 8'h01, 1'b1, 16'hAAAA, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tbl[2]  = v(1'b0, 1'b1, 16'h1111, 8'h01, 1'b1, 16'hAAAA, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tbl[3]  = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        tbl[4]  = v(1'b1, 1'b1, 16'h1234, 8'h05, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 16'h1234);
        tbl[5]  = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hBEEF, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h05, 16'h1234);
        tbl[6]  = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0A, 16'hBEEF);
        tbl[7]  = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0A, 16'hBEEF);
        tbl[8]  = v(1'b1, 1'b1, 16'h0001, 8'h10, 1'b1, 16'hC001, 8'h21, 1'b0, 1'b1, 1'b1, 8'h10, 16'h0001);
        tbl[9]  = v(1'b1, 1'b1, 16'h0002, 8'h11, 1'b1, 16'hC002, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 16'h0002);
        tbl[10] = v(1'b1, 1'b1, 16'h0003, 8'h12, 1'b1, 16'hC003, 8'h23, 1'b0, 1'b0, 1'b1, 8'h12, 16'h0003);
        tbl[11] = v(1'b1, 1'b1, 16'h0004, 8'h13, 1'b1, 16'hC003, 8'h23, 1'b0, 1'b0, 1'b1, 8'h13, 16'h0004);
        tbl[12] = v(1'b1, 1'b1, 16'h0005, 8'h14, 1'b1, 16'hC003, 8'h23, 1'b1, 1'b0, 1'b1, 8'h21, 16'hC001);
        tbl[13] = v(1'b1, 1'b1, 16'h0005, 8'h14, 1'b1, 16'hC003, 8'h23, 1'b0, 1'b1, 1'b1, 8'h14, 16'h0005);
        tbl[14] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 16'hC002);
        tbl[15] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h23, 16'hC003);
        tbl[16] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h5555, 8'h30, 1'b0, 1'b1, 1'b0, 8'h23, 16'hC003);
        tbl[17] = v(1'b1, 1'b1, 16'h0100, 8'h40, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h40, 16'h0100);
        tbl[18] = v(1'b1, 1'b1, 16'h0101, 8'h41, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 16'h0101);
        tbl[19] = v(1'b1, 1'b1, 16'h0102, 8'h42, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 16'h0102);
        tbl[20] = v(1'b1, 1'b1, 16'h0103, 8'h43, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'h30, 16'h5555);
        tbl[21] = v(1'b1, 1'b1, 16'h0103, 8'h43, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h43, 16'h0103);
        tbl[22] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h6666, 8'h50, 1'b0, 1'b1, 1'b0, 8'h43, 16'h0103);
        tbl[23] = v(1'b0, 1'b1, 16'h7777, 8'h01, 1'b1, 16'h8888, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        tbl[24] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);

        // Same-register hazard: queued entry to 0x07 must land before the younger writeback to 0x07
        hz[0] = v(1'b1, 1'b1, 16'h0001, 8'h01, 1'b1, 16'hAAAA, 8'h07, 1'b0, 1'b1, 1'b1, 8'h01, 16'h0001);
        hz[1] = v(1'b1, 1'b1, 16'h0777, 8'h07, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 16'hAAAA);
        hz[2] = v(1'b1, 1'b1, 16'h0777, 8'h07, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h07, 16'h0777);
        hz[3] = v(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h07, 16'h0777);

        rst_n = 1'b0; wb_we = 1'b0; wb_res = '0; wb_reg = '0;
        mc_valid = 1'b0; mc_res = '0; mc_reg = '0;
        @(posedge clk);
        model_update();
        #1;

        foreach (tbl[i]) run_cycle(tbl[i], 1'b0);
`ifdef WB_ARB_HAZARD_EN
        foreach (hz[i]) run_cycle(hz[i], 1'b0);
`endif

        for (int k = 0; k < 800; k++) begin
            rv = v(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                   8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                   8'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
            run_cycle(rv, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
